// File: rtl/step_pkg.sv
// step_pkg: shared constants for the tiny16 T-state sequencer.
// Default counter width/step count and named step values T0..T7.
package step_pkg;

  localparam int STEP_WIDTH = 3;
  localparam int STEP_COUNT = 8;

  localparam logic [STEP_WIDTH-1:0] T0 = 3'd0;
  localparam logic [STEP_WIDTH-1:0] T1 = 3'd1;
  localparam logic [STEP_WIDTH-1:0] T2 = 3'd2;
  localparam logic [STEP_WIDTH-1:0] T3 = 3'd3;
  localparam logic [STEP_WIDTH-1:0] T4 = 3'd4;
  localparam logic [STEP_WIDTH-1:0] T5 = 3'd5;
  localparam logic [STEP_WIDTH-1:0] T6 = 3'd6;
  localparam logic [STEP_WIDTH-1:0] T7 = 3'd7;

endpackage

// File: rtl/step.sv
// step: free-running T-state counter with one-hot and first/last flags.
// Ports: clk, rst (async active-low), counter, step_onehot, first_step, last_step.
module step
  import step_pkg::*;
#(
  parameter int WIDTH     = STEP_WIDTH,
  parameter int NUM_STEPS = STEP_COUNT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WIDTH-1:0]     counter,
  output logic [NUM_STEPS-1:0] step_onehot,
  output logic                 first_step,
  output logic                 last_step
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(NUM_STEPS - 1);

  logic [WIDTH-1:0]     r_counter;
  logic [NUM_STEPS-1:0] w_onehot;

  // >= also catches any out-of-range value and reloads 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_counter <= '0;
    end else if (r_counter >= LAST) begin
      r_counter <= '0;
    end else begin
      r_counter <= r_counter + 1'b1;
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      w_onehot[i] = (r_counter == WIDTH'(i));
    end
  end

  assign counter     = r_counter;
  assign step_onehot = w_onehot;
  assign first_step  = (r_counter == '0);
  assign last_step   = (r_counter == LAST);

endmodule

// File: tb/tb_step.sv
// tb_step: scoreboard bench for step, default (8) and NUM_STEPS=5 builds.
// Stimulus pushes expectations; a monitor pops and compares.
module tb_step;

  logic       clk;
  logic       rst8;
  logic       rst5;
  logic [2:0] cnt8;
  logic [7:0] oh8;
  logic       f8;
  logic       l8;
  logic [2:0] cnt5;
  logic [4:0] oh5;
  logic       f5;
  logic       l5;

  step #(.WIDTH(3), .NUM_STEPS(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst8),
    .counter     (cnt8),
    .step_onehot (oh8),
    .first_step  (f8),
    .last_step   (l8)
  );

  step #(.WIDTH(3), .NUM_STEPS(5)) u_dut5 (
    .clk         (clk),
    .rst         (rst5),
    .counter     (cnt5),
    .step_onehot (oh5),
    .first_step  (f5),
    .last_step   (l5)
  );

  typedef struct {
    int         sel;
    string      name;
    logic [2:0] cnt;
    logic [7:0] oh;
    logic       f;
    logic       l;
  } exp_t;

  exp_t q[$];
  event ev_chk;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // expected flags derived from the hand-written step value
  task automatic expect_step(input int sel, input string name,
                             input int c);
    exp_t e;
    int   n;
    n      = (sel == 5) ? 5 : 8;
    e.sel  = sel;
    e.name = name;
    e.cnt  = 3'(c);
    e.oh   = 8'(1 << c);
    e.f    = (c == 0);
    e.l    = (c == n - 1);
    q.push_back(e);
    -> ev_chk;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [2:0] ac;
    logic [7:0] ao;
    logic       af;
    logic       al;
    forever begin
      @(ev_chk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel == 5) begin
          ac = cnt5; ao = {3'b000, oh5}; af = f5; al = l5;
        end else begin
          ac = cnt8; ao = oh8; af = f8; al = l8;
        end
        checks++;
        if (ac !== e.cnt || ao !== e.oh || af !== e.f || al !== e.l) begin
          errors++;
          $display("FAIL %s: got cnt=%0d oh=%b first=%b last=%b, want cnt=%0d oh=%b first=%b last=%b",
                   e.name, ac, ao, af, al, e.cnt, e.oh, e.f, e.l);
        end
      end
    end
  end

  initial begin : watchdog
    #5000;
    $display("FAIL watchdog: got timeout, want finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  int seq9 [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
  int seq5 [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};

  initial begin : stim
    rst8 = 1'b0;
    rst5 = 1'b0;
    #11;
    expect_step(8, "reset", 0);
    #1;
    rst8 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      expect_step(8, $sformatf("count%0d", i), seq9[i]);
    end
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      expect_step(8, $sformatf("run%0d", i), i);
    end
    // async reset between edges at step 5
    rst8 = 1'b0;
    #1;
    expect_step(8, "async_rst", 0);
    @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    expect_step(8, "after_async", 1);
    // release coinciding with a rising edge
    rst8 = 1'b0;
    @(posedge clk);
    rst8 <= 1'b1;
    @(negedge clk);
    expect_step(8, "coincide_hold", 0);
    @(negedge clk);
    expect_step(8, "coincide_next", 1);
    // NUM_STEPS = 5 build
    expect_step(5, "n5_reset", 0);
    rst5 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      expect_step(5, $sformatf("n5_seq%0d", i), seq5[i]);
    end
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
